// File: rtl/timebase_pkg.sv
// Shared FSM encoding and widths for the timebase controller and its bench-facing outputs.
package timebase_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam int unsigned TICK_COUNT_W = 16;

    // Divisor loads are only taken while the counter is not advancing.
    function automatic logic load_window(input state_e s);
        return (s == ST_IDLE) || (s == ST_PAUSE);
    endfunction

endpackage

// File: rtl/tick_counter.sv
// Count/compare/wrap datapath: counts while enabled and emits a registered one-clock tick
// on the edge where the count wraps from div back to zero.
module tick_counter #(
    parameter int unsigned CNT_WIDTH = 17
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [CNT_WIDTH-1:0] div,
    output logic                 tick,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(32'd1);

    logic [CNT_WIDTH-1:0] count_d, count_q;
    logic                 tick_d, tick_q;

    // Next count: clear wins over counting; tick only on the wrap edge.
    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        if (clear) begin
            count_d = CNT_ZERO;
        end else if (enable) begin
            if (count_q == div) begin
                count_d = CNT_ZERO;
                tick_d  = 1'b1;
            end else begin
                count_d = count_q + CNT_ONE;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Counter and tick registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= CNT_ZERO;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign tick  = tick_q;
    assign count = count_q;

endmodule

// File: rtl/timebase_ctrl.sv
// Run/pause/stop controller around tick_counter: owns the FSM, the divisor load handshake
// and the 16-bit running tick count.
module timebase_ctrl #(
    parameter int unsigned CNT_WIDTH = 17
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 stop,
    input  logic                 load_valid,
    input  logic [CNT_WIDTH-1:0] load_div,
    output logic                 load_ready,
    output logic                 tick,
    output logic [15:0]          tick_count,
    output logic [1:0]           state
);

    import timebase_pkg::*;

    state_e                    state_d, state_q;
    logic [CNT_WIDTH-1:0]      div_d, div_q;
    logic [TICK_COUNT_W-1:0]   tick_count_d, tick_count_q;
    logic                      load_ready_s, load_acc_s, start_idle_s;
    logic                      cnt_en_s, cnt_clr_s, wrap_s, tick_s;
    logic [CNT_WIDTH-1:0]      count_s;

    // Request decode shared by the FSM, the counter controls and tick_count.
    always_comb begin
        load_ready_s = load_window(state_q);
        start_idle_s = (state_q == ST_IDLE) && start && !stop;
        // Stop also blocks a same-cycle load so the divisor survives an abort.
        load_acc_s   = load_valid && load_ready_s && !stop;
        cnt_en_s     = (state_q == ST_RUN) && !stop && !pause;
        cnt_clr_s    = stop || load_acc_s || start_idle_s;
        wrap_s       = cnt_en_s && (count_s == div_q);
    end

    // Next state with priority stop > pause > start; pause is meaningless outside RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (stop)       state_d = ST_IDLE;
                else if (start) state_d = ST_RUN;
                else            state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (stop)       state_d = ST_IDLE;
                else if (pause) state_d = ST_PAUSE;
                else            state_d = ST_RUN;
            end
            ST_PAUSE: begin
                if (stop)       state_d = ST_IDLE;
                else if (start) state_d = ST_RUN;
                else            state_d = ST_PAUSE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Divisor register and tick_count next values.
    always_comb begin
        div_d        = div_q;
        tick_count_d = tick_count_q;
        if (load_acc_s) begin
            div_d = load_div;
        end else begin
            div_d = div_q;
        end
        if (start_idle_s) begin
            tick_count_d = 16'd0;
        end else if (wrap_s) begin
            tick_count_d = tick_count_q + 16'd1;
        end else begin
            tick_count_d = tick_count_q;
        end
    end

    // Control registers; divisor resets to the slowest rate.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            div_q        <= {CNT_WIDTH{1'b1}};
            tick_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            tick_count_q <= tick_count_d;
        end
    end

    tick_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_tick_counter (
        .clock  (clock),
        .reset  (reset),
        .enable (cnt_en_s),
        .clear  (cnt_clr_s),
        .div    (div_q),
        .tick   (tick_s),
        .count  (count_s)
    );

    assign load_ready = load_ready_s;
    assign tick       = tick_s;
    assign tick_count = tick_count_q;
    assign state      = state_q;

endmodule

// File: doc/timebase_ctrl.md
TIMEBASE_CTRL -- requirements
Module: timebase_ctrl

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 17, divisor/counter width in bits (range 1..32).
REQ-002 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  run request: IDLE->RUN or PAUSE->RUN.
REQ-005 SHALL have port pause  input  1  pause request: RUN->PAUSE.
REQ-006 SHALL have port stop  input  1  abort request: any state->IDLE.
REQ-007 SHALL have port load_valid  input  1  divisor load request.
REQ-008 SHALL have port load_div  input  CNT_WIDTH  new divisor value D; tick period is D+1 clocks.
REQ-009 SHALL have port load_ready  output  1  divisor load may be accepted this cycle.
REQ-010 SHALL have port tick  output  1  one-clock-wide enable pulse, registered.
REQ-011 SHALL have port tick_count  output  16  number of ticks since last start from IDLE.
REQ-012 SHALL have port state  output  2  current FSM state: IDLE=0, RUN=1, PAUSE=2; 3 unused.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, PAUSE; encoding 3 never entered.
REQ-014 SHALL apply request priority stop > pause > start when several are high in one cycle.
REQ-015 SHALL, on stop in any state: go to IDLE; clear count to 0; hold tick_count; deassert tick next cycle.
REQ-016 SHALL, on start in IDLE: go to RUN; clear count and tick_count to 0.
REQ-017 SHALL, on pause in RUN: go to PAUSE; hold count and tick_count.
REQ-018 SHALL, on start in PAUSE: go to RUN; resume from the held count.
REQ-019 SHALL ignore pause in IDLE or PAUSE, and start in RUN.
REQ-020 SHALL, in RUN, increment the internal CNT_WIDTH-bit count each clock; when count == div_reg, count returns to 0 and tick is 1 in the following cycle.
REQ-021 SHALL produce the first tick D+1 clocks after the RUN-entry edge; period D+1 thereafter; D=0 gives tick high every RUN cycle.
REQ-022 SHALL keep tick at 0 in IDLE and PAUSE, including the edge that enters PAUSE.
REQ-023 SHALL increment tick_count by 1 per tick, wrapping 16'hFFFF -> 16'h0000 with no flag.
REQ-024 SHALL drive load_ready = 1 exactly when state is IDLE or PAUSE (combinational from state).
REQ-025 SHALL accept a load on an edge with load_valid && load_ready: div_reg <= load_div, count <= 0.
REQ-026 SHALL, for a simultaneous load and start in IDLE or PAUSE, take both: RUN entered with the new div_reg and count 0.
REQ-027 SHALL ignore load_valid in RUN; div_reg is unchanged and there is no queueing.
REQ-028 SHALL keep div_reg unchanged when stop is applied.

Reset
REQ-029 SHALL, while reset is high, asynchronously force: state=IDLE, count=0, div_reg=all ones (2^CNT_WIDTH-1), tick=0, tick_count=0, load_ready=1.
REQ-030 SHALL, on reset asserted mid-RUN, drop tick in the same cycle without waiting for a clock edge.
REQ-031 SHALL remain in IDLE after reset deasserts until a start is sampled.

Structure
REQ-032 SHALL place the state encoding constants (IDLE/RUN/PAUSE) in shared package timebase_pkg.
REQ-033 SHALL implement the count/compare/wrap datapath in one sub-module, tick_counter (enable, clear, div in; tick, count out); the FSM, load handshake and tick_count stay in timebase_ctrl.

Verification
REQ-034 SHALL cover: reset, load D=3 in IDLE, start -> ticks on cycles 4, 8, 12 after the start edge; tick_count 1, 2, 3.
REQ-035 SHALL cover: D=4, run, pause 2 clocks after a tick, hold 10 clocks, start -> no tick while paused; next tick 3 clocks after resume; load_ready 1 only during the pause.
REQ-036 SHALL cover: in RUN, load_valid with D=1 -> ignored, period stays 4; stop, then load D=1 and start in the same cycle -> period 2.
REQ-037 SHALL cover: start+pause+stop in the same cycle from RUN -> IDLE; start+pause from RUN -> PAUSE.
REQ-038 SHALL cover: D=0, run 65537 clocks -> tick constantly 1; tick_count wraps to 0x0001.
REQ-039 SHALL cover: async reset pulse between edges mid-RUN -> tick=0, state=IDLE, div_reg all ones immediately.
